wb_shared_dmem: RTL and testbench
=================================

Name: wb_shared_dmem

Overview:
- Wishbone classic responder that lets the Caravel management core read and write the processor's data memory while the core runs.
- Sits beside the memory controller on the processor data port. It owns a word-addressed register-array memory, arbitrates between processor and Wishbone accesses, and asserts a stall toward the processor when Wishbone takes the array.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words).
- BASE_ADDR, 32'h3000_0000, Wishbone window base; the window spans 4*2^DEPTH_LOG2 bytes.
- WAIT_MAX, 4, maximum cycles a pending Wishbone request waits behind processor traffic.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  Wishbone write enable.
- wbs_sel_i  input  4  Wishbone byte selects.
- wbs_dat_i  input  32  Wishbone write data.
- wbs_adr_i  input  32  Wishbone byte address.
- wbs_ack_o  output  1  Wishbone acknowledge.
- wbs_dat_o  output  32  Wishbone read data.
- proc_en  input  1  processor data access valid this cycle.
- proc_we  input  1  processor write enable.
- proc_addr  input  32  processor byte address; offset from 0 within the array.
- proc_wdata  input  32  processor write data, full word.
- proc_rdata  output  32  processor read data, combinational.
- proc_stall  output  1  processor must hold its current access.

Behaviour:
- Reset state: FSM IDLE, wbs_ack_o=0, wbs_dat_o=0, proc_stall=0, wait counter=0. Memory contents are not cleared.
- Word index = addr[DEPTH_LOG2+1:2]. Address bits [1:0] are ignored.
- Wishbone hit = cyc & stb & (adr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]). A miss is never acknowledged; it is left for other slaves.
- Processor in-range = proc_addr[31:DEPTH_LOG2+2]==0.
  - Out of range: proc_rdata=0 and writes are dropped.
- proc_rdata = mem[index], combinational. It shows the old value in the cycle of a same-address write.
- Processor write commits at the rising edge when proc_en & proc_we & in-range & !proc_stall.
- FSM states:
  - IDLE:
    - On a hit with proc_en=0, go to WB_ACCESS.
    - On a hit with proc_en=1, increment the wait counter. When the counter equals WAIT_MAX, go to WB_ACCESS and clear the counter.
    - With no hit, clear the counter.
  - WB_ACCESS (exactly 1 cycle):
    - proc_stall=1 combinationally; processor writes are blocked.
    - For a write, each byte lane i with sel[i]=1 is written from dat_i; other lanes are unchanged.
    - For a read, wbs_dat_o <= mem[index].
    - Next state is WB_ACK.
  - WB_ACK (exactly 1 cycle):
    - wbs_ack_o=1 (registered) and wbs_dat_o is held.
    - Next state is IDLE.
    - The master drops stb on the ack edge, so the same transfer is not re-accepted.
- Latency from hit to ack:
  - Idle processor: ack is high on the 3rd cycle after stb rises (IDLE, ACCESS, ACK).
  - Busy processor: add WAIT_MAX cycles.
- Starvation guard: proc_stall is high only during WB_ACCESS. The processor loses at most 1 cycle per Wishbone transfer.
- Request withdrawal: if cyc or stb drops while in IDLE waiting, clear the counter and perform no access.
- A transfer that reaches WB_ACCESS always completes, even if stb drops.
- Asynchronous reset at any point returns to IDLE with ack low. An in-flight Wishbone write is either fully committed or not at all; there are no partial byte lanes.
- After WB_ACK, wbs_dat_o keeps its last value.

Test Plan:
- Reset: assert reset mid-WB_ACCESS -> wbs_ack_o=0, proc_stall=0, wbs_dat_o=0 immediately; FSM IDLE after release.
- WB write then read, proc_en=0:
  - Write adr=0x3000_0010, dat=0xDEADBEEF, sel=4'hF -> ack on 3rd cycle.
  - Read the same address -> wbs_dat_o=0xDEADBEEF.
  - proc_addr=0x10 -> proc_rdata=0xDEADBEEF.
- Byte lanes:
  - Preload 0x11223344 at word 5, then WB write sel=4'b0101, dat=0xAABBCCDD -> word reads 0x11BB33DD.
- Starvation: proc_en held 1 (reads) while WB read pending -> proc_stall high exactly one cycle after 4 wait cycles; ack 6 cycles after stb.
- Contention with processor write:
  - Processor writes 0x5 to word 2 while WB writes 0x7 to word 2; proc_en high throughout.
  - Processor write precedes and is not blocked except during WB_ACCESS; final value 0x7.
  - The processor write stalled during WB_ACCESS commits the cycle after -> final value 0x5.
- Misses and range:
  - WB adr=0x3000_0400 (outside the 1 KiB window) -> no ack for 10 cycles.
  - proc_addr=0x400 -> proc_rdata=0 and no write.
  - Withdrawn request -> no memory change.

Source files
------------

// File: rtl/wb_shared_dmem.sv
// Shared data memory: the processor port reads and writes it every cycle, and a
// Wishbone classic window onto the same words lets the management core get in.
module wb_shared_dmem #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          WAIT_MAX   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        proc_en,
  input  logic        proc_we,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_wdata,
  output logic [31:0] proc_rdata,
  output logic        proc_stall
);

  localparam int            DEPTH    = 1 << DEPTH_LOG2;
  localparam int            CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, WB_ACCESS, WB_ACK} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         wait_cnt, wait_cnt_next;
  logic [31:0]           mem [DEPTH];
  logic                  wb_hit, take;
  logic                  proc_in_range, proc_wr;
  logic [DEPTH_LOG2-1:0] wb_idx, proc_idx, req_idx;
  logic                  req_we;
  logic [3:0]            req_sel;
  logic [31:0]           req_dat;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{wbs_adr_i[1:0], proc_addr[1:0]};

  // Wishbone handshake: a request is cyc & stb inside the window; it is taken
  // once, held in req_* so it finishes even if stb drops, and answered with a
  // one-cycle registered ack two cycles after it is taken. Misses never ack.
  assign wb_hit = wbs_cyc_i & wbs_stb_i &
                  (wbs_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign wb_idx = wbs_adr_i[DEPTH_LOG2+1:2];

  assign proc_in_range = (proc_addr[31:DEPTH_LOG2+2] == '0);
  assign proc_idx      = proc_addr[DEPTH_LOG2+1:2];
  assign proc_stall    = (state == WB_ACCESS);
  assign proc_rdata    = proc_in_range ? mem[proc_idx] : 32'h0;
  assign proc_wr       = proc_en & proc_we & proc_in_range & ~proc_stall;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    take          = 1'b0;
    case (state)
      IDLE: begin
        if (!wb_hit) begin
          wait_cnt_next = '0;
        end else if (!proc_en || wait_cnt == WAIT_LIM) begin
          take          = 1'b1;
          wait_cnt_next = '0;
          state_next    = WB_ACCESS;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      WB_ACCESS: state_next = WB_ACK;
      WB_ACK:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      req_we    <= 1'b0;
      req_sel   <= 4'h0;
      req_dat   <= 32'h0;
      req_idx   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      wbs_ack_o <= (state == WB_ACCESS);
      if (state == WB_ACCESS && !req_we) wbs_dat_o <= mem[req_idx];
      if (take) begin
        req_we  <= wbs_we_i;
        req_sel <= wbs_sel_i;
        req_dat <= wbs_dat_i;
        req_idx <= wb_idx;
      end
    end
  end

  // Processor writes are stalled during WB_ACCESS, so the two writers never meet.
  always_ff @(posedge clk) begin
    if (proc_wr) mem[proc_idx] <= proc_wdata;
    if (state == WB_ACCESS && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_sel[i]) mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_shared_dmem.sv
// Bench for wb_shared_dmem: a transfer-scheduling model of the memory and the
// Wishbone window, checked every cycle, plus directed literal checks.
module tb_wb_shared_dmem;
  localparam int          DL   = 8;
  localparam int          WM   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk, rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        proc_en, proc_we, proc_stall;
  logic [31:0] proc_addr, proc_wdata, proc_rdata;

  int tests = 0;
  int failed = 0;
  bit chk_en = 0;
  int proc_mode = 0;

  wb_shared_dmem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .proc_en(proc_en), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >> (DL + 2)) == (BASE >> (DL + 2));
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> (DL + 2)) == 32'h0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  // reference model: a transfer taken in cycle t owns the array in cycle t+1
  // and is acknowledged in cycle t+2
  logic [31:0] mdl_mem [256];
  bit          mdl_valid [256];
  int          cyc_n = 0;
  int          acc_cycle = -10;
  int          wait_n = 0;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  int          req_idx;
  logic [31:0] exp_dat = 32'h0;

  always @(posedge clk) begin : model
    int c;
    bit hit, stall_now;
    c = cyc_n;
    stall_now = 0;
    if (rst) begin
      acc_cycle = -10;
      wait_n = 0;
      exp_dat = 32'h0;
    end else begin
      stall_now = (c == acc_cycle);
      if (stall_now) begin
        if (req_we) begin
          for (int i = 0; i < 4; i++)
            if (req_sel[i]) mdl_mem[req_idx][8*i +: 8] = req_dat[8*i +: 8];
        end else begin
          exp_dat = mdl_mem[req_idx];
        end
      end
      hit = wbs_cyc_i && wbs_stb_i && in_win(wbs_adr_i);
      if (c > acc_cycle + 1) begin
        if (!hit) wait_n = 0;
        else if (!proc_en || wait_n == WM) begin
          acc_cycle = c + 1;
          wait_n = 0;
          req_we = wbs_we_i;
          req_sel = wbs_sel_i;
          req_dat = wbs_dat_i;
          req_idx = widx(wbs_adr_i);
        end else wait_n++;
      end
    end
    if (proc_en && proc_we && in_rng(proc_addr) && !stall_now) begin
      mdl_mem[widx(proc_addr)] = proc_wdata;
      mdl_valid[widx(proc_addr)] = 1;
    end
    cyc_n = c + 1;
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_stall", 32'(proc_stall), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
      end else begin
        chk("ack", 32'(wbs_ack_o), 32'(cyc_n == acc_cycle + 1));
        chk("stall", 32'(proc_stall), 32'(cyc_n == acc_cycle));
        chk("wb_dat", wbs_dat_o, exp_dat);
      end
      if (!in_rng(proc_addr)) chk("rdata_oor", proc_rdata, 32'h0);
      else if (mdl_valid[widx(proc_addr)]) chk("rdata", proc_rdata, mdl_mem[widx(proc_addr)]);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (proc_mode == 1) begin
      proc_en = ($urandom_range(0, 3) != 0);
      proc_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) proc_addr = 32'h400 + ($urandom_range(0, 15) << 2);
      else proc_addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      proc_wdata = $urandom;
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int wr_stop,
                         output int lat, output int stall_n, output logic [31:0] rd);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = adr; wbs_we_i = we;
    wbs_sel_i = sel; wbs_dat_i = dat;
    lat = 0; stall_n = 0;
    while (!wbs_ack_o && lat < 20) begin
      step();
      lat++;
      if (lat == wr_stop) proc_we = 0;
      if (proc_stall) stall_n++;
    end
    chk("ack_timeout", 32'(wbs_ack_o), 32'h1);
    rd = wbs_dat_o;
    step();
    wbs_cyc_i = 0; wbs_stb_i = 0;
  endtask

  task automatic wb_miss(input logic [31:0] adr, input int n, output int acks);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = adr; wbs_we_i = 0;
    acks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
  endtask

  initial begin : watchdog
    #500000;
    failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, stn, acks;
    logic [31:0] rd;
    rst = 0; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_dat_i = 0; wbs_adr_i = 0; proc_en = 0; proc_we = 0; proc_addr = 0; proc_wdata = 0;
    #3 rst = 1;
    chk_en = 1;
    step(); step();
    rst = 0;

    // preload every word from the processor side
    proc_mode = 2;
    for (int i = 0; i < 256; i++) begin
      proc_en = 1; proc_we = 1; proc_addr = i << 2;
      proc_wdata = (i == 5) ? 32'h1122_3344 : (i == 7) ? 32'h7777_7777 :
                   (i == 8) ? 32'h8888_8888 : $urandom;
      step();
    end
    proc_en = 0; proc_we = 0;

    // idle-processor write then read
    wb_xfer(32'h3000_0010, 1, 4'hF, 32'hDEAD_BEEF, -1, lat, stn, rd);
    chk("wr_latency", lat, 2);
    wb_xfer(32'h3000_0010, 0, 4'hF, 32'h0, -1, lat, stn, rd);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    proc_addr = 32'h10; #1;
    chk("proc_sees_wb", proc_rdata, 32'hDEAD_BEEF);

    // byte lanes
    wb_xfer(32'h3000_0014, 1, 4'b0101, 32'hAABB_CCDD, -1, lat, stn, rd);
    wb_xfer(32'h3000_0014, 0, 4'hF, 32'h0, -1, lat, stn, rd);
    chk("byte_lanes", rd, 32'h11BB_33DD);

    // starvation guard with a busy processor
    proc_en = 1; proc_we = 0; proc_addr = 32'h10;
    wb_xfer(32'h3000_0010, 0, 4'hF, 32'h0, -1, lat, stn, rd);
    chk("busy_latency", lat, 6);
    chk("busy_stall_cycles", stn, 1);
    chk("busy_rd", rd, 32'hDEAD_BEEF);

    // contention on word 2
    proc_en = 1; proc_we = 1; proc_addr = 32'h8; proc_wdata = 32'h5;
    wb_xfer(32'h3000_0008, 1, 4'hF, 32'h7, 1, lat, stn, rd);
    proc_we = 0; #1;
    chk("contend_wb_last", proc_rdata, 32'h7);
    proc_we = 1;
    wb_xfer(32'h3000_0008, 1, 4'hF, 32'h7, -1, lat, stn, rd);
    proc_we = 0; #1;
    chk("contend_proc_last", proc_rdata, 32'h5);
    proc_en = 0;

    // misses and range
    wb_miss(32'h3000_0400, 10, acks);
    chk("miss_no_ack", acks, 0);
    proc_addr = 32'h400; #1;
    chk("proc_oor_rdata", proc_rdata, 32'h0);
    proc_en = 1; proc_we = 1; proc_addr = 32'h0; proc_wdata = 32'h1234_5678;
    step();
    proc_addr = 32'h400; proc_wdata = 32'hFFFF_FFFF;
    step();
    proc_en = 0; proc_we = 0; proc_addr = 32'h0; #1;
    chk("oor_write_dropped", proc_rdata, 32'h1234_5678);

    // withdrawn request while the processor is busy
    proc_en = 1; proc_we = 0; proc_addr = 32'h20;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'hBAD0_BAD0;
    step(); step();
    wbs_cyc_i = 0; wbs_stb_i = 0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wbs_ack_o) acks++;
    end
    chk("withdraw_no_ack", acks, 0);
    chk("withdraw_no_write", proc_rdata, 32'h8888_8888);
    wb_xfer(32'h3000_0020, 0, 4'hF, 32'h0, -1, lat, stn, rd);
    chk("withdraw_counter_cleared", lat, 6);
    chk("withdraw_rd", rd, 32'h8888_8888);
    proc_en = 0;

    // reset in the middle of WB_ACCESS
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_001C; wbs_dat_i = 32'hCAFE_F00D;
    step();
    chk("mid_access_stall", 32'(proc_stall), 32'h1);
    #2 rst = 1;
    #1;
    chk("async_rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("async_rst_stall", 32'(proc_stall), 32'h0);
    chk("async_rst_dat", wbs_dat_o, 32'h0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    step(); step();
    rst = 0;
    proc_addr = 32'h1C; #1;
    chk("rst_write_aborted", proc_rdata, 32'h7777_7777);
    wb_xfer(32'h3000_001C, 0, 4'hF, 32'h0, -1, lat, stn, rd);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_rd", rd, 32'h7777_7777);

    // randomized traffic on both ports
    proc_mode = 1;
    for (int n = 0; n < 60; n++) begin
      int gap;
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 32'h3000_0400 + ($urandom_range(0, 15) << 2)
                                         : 32'h2000_0000 + ($urandom_range(0, 15) << 2);
        wb_miss(a, 4, acks);
        chk("rand_miss_no_ack", acks, 0);
      end else begin
        a = BASE + (($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        wb_xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, -1,
                lat, stn, rd);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end
    proc_mode = 2;
    proc_en = 0; proc_we = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
